// File: rtl/jtag_pkg.sv
// Shared widths, completion codes and FSM state encoding for the AXI transaction controller.
package jtag_pkg;

  localparam int ADDR_AXI_WIDTH = 32;
  localparam int DATA_AXI_WIDTH = 32;

  typedef enum logic [2:0] {
    STS_OKAY    = 3'd0,
    STS_EXOKAY  = 3'd1,
    STS_SLVERR  = 3'd2,
    STS_DECERR  = 3'd3,
    STS_TIMEOUT = 3'd4
  } axi_txn_sts_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } txn_state_t;

endpackage

// File: rtl/axi_txn_ctrl.sv
// Single-beat AXI master: turns one command into one AXI read or write with a timeout.
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered, each dropped on its own handshake
// WR_RESP | waiting for B
// RD_REQ  | AR offered
// RD_RESP | waiting for R
// DONE    | one-cycle sts_valid pulse
module axi_txn_ctrl
  import jtag_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_AXI_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_AXI_WIDTH-1:0]   cmd_wdata,
  output logic                        sts_valid,
  output logic [2:0]                  sts_status,
  output logic [DATA_AXI_WIDTH-1:0]   sts_rdata,
  output logic [ADDR_AXI_WIDTH-1:0]   m_awaddr,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [DATA_AXI_WIDTH-1:0]   m_wdata,
  output logic [DATA_AXI_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic [ADDR_AXI_WIDTH-1:0]   m_araddr,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_AXI_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rvalid,
  output logic                        m_rready
);

  txn_state_t                state_q, state_d;
  logic [15:0]               cnt_q;
  logic                      aw_done_q, w_done_q;
  logic [ADDR_AXI_WIDTH-1:0] addr_q;
  logic [DATA_AXI_WIDTH-1:0] wdata_q;
  axi_txn_sts_t              sts_q, sts_d;
  logic [DATA_AXI_WIDTH-1:0] rdata_q, rdata_d;
  logic                      sts_upd, accept, aw_hs, w_hs, tmo;

  // Expires on the TIMEOUT_CYCLES-th non-idle cycle; a handshake in that cycle still wins.
  assign tmo = (int'(cnt_q) >= TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    sts_valid = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    accept    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    sts_upd   = 1'b0;
    sts_d     = STS_OKAY;
    rdata_d   = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        aw_hs     = !aw_done_q && m_awready;
        w_hs      = !w_done_q && m_wready;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
        else if (tmo) begin
          sts_upd = 1'b1;
          sts_d   = STS_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid || tmo) begin
          sts_upd = 1'b1;
          sts_d   = m_bvalid ? axi_txn_sts_t'({1'b0, m_bresp}) : STS_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_RD_RESP;
        else if (tmo) begin
          sts_upd = 1'b1;
          sts_d   = STS_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_RD_RESP: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          sts_upd = 1'b1;
          sts_d   = axi_txn_sts_t'({1'b0, m_rresp});
          rdata_d = m_rdata;
          state_d = ST_DONE;
        end else if (tmo) begin
          sts_upd = 1'b1;
          sts_d   = STS_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        sts_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sts_q     <= STS_OKAY;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
      end else begin
        if (state_q != ST_IDLE && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (sts_upd) begin
        sts_q   <= sts_d;
        rdata_q <= rdata_d;
      end
    end
  end

  assign m_awaddr   = addr_q;
  assign m_araddr   = addr_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = '1;
  assign sts_status = sts_q;
  assign sts_rdata  = rdata_q;

endmodule

// File: doc/axi_txn_ctrl.md
AXI_TXN_CTRL -- requirements
Module: axi_txn_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles allowed from command accept to completion before abort.
REQ-002 SHALL have ports (one per line; widths from jtag_pkg ADDR_AXI_WIDTH=AW, DATA_AXI_WIDTH=DW):
 clk  in  1  sole clock; reset is synchronous and active-high
 rst  in  1  synchronous active-high reset
 cmd_valid  in  1  command request
 cmd_ready  out  1  high only in IDLE
 cmd_write  in  1  1=write, 0=read
 cmd_addr  in  AW  target address
 cmd_wdata  in  DW  write data
 sts_valid  out  1  one-cycle completion pulse
 sts_status  out  3  axi_txn_sts_t completion code
 sts_rdata  out  DW  read data of last completed read
 m_awaddr  out  AW  write address
 m_awvalid  out  1  write address valid
 m_awready  in  1  write address ready
 m_wdata  out  DW  write data
 m_wstrb  out  DW/8  write strobe, all ones
 m_wvalid  out  1  write data valid
 m_wready  in  1  write data ready
 m_bresp  in  2  write response
 m_bvalid  in  1  write response valid
 m_bready  out  1  write response ready
 m_araddr  out  AW  read address
 m_arvalid  out  1  read address valid
 m_arready  in  1  read address ready
 m_rdata  in  DW  read data
 m_rresp  in  2  read response
 m_rvalid  in  1  read data valid
 m_rready  out  1  read data ready
REQ-003 SHALL treat all command inputs as synchronous to clk; tck-domain crossing is outside this block.

Function
REQ-004 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-005 SHALL accept a command on cmd_valid&&cmd_ready, latch addr/wdata/write, enter WR_REQ (write) or RD_REQ (read); AXI valids assert the following cycle.
REQ-006 WR_REQ SHALL assert m_awvalid and m_wvalid together, deassert each independently on its own handshake, and enter WR_RESP the cycle after both handshakes complete (same-cycle or either order).
REQ-007 WR_RESP SHALL hold m_bready=1; on m_bvalid capture {1'b0,m_bresp} into status, clear sts_rdata to 0, enter DONE.
REQ-008 RD_REQ SHALL hold m_arvalid until m_arready, then enter RD_RESP; RD_RESP SHALL hold m_rready=1 and on m_rvalid capture m_rdata and {1'b0,m_rresp}, enter DONE.
REQ-009 DONE SHALL last exactly one cycle with sts_valid=1, then return to IDLE; sts_status/sts_rdata SHALL hold until the next completion.
REQ-010 A 16-bit saturating counter SHALL clear on accept and increment each non-IDLE cycle; reaching TIMEOUT_CYCLES before completion SHALL drop all AXI valids/readies, set status TIMEOUT (3'b100), sts_rdata=0, enter DONE.
REQ-011 Handshake on the same cycle the counter reaches TIMEOUT_CYCLES SHALL win over timeout.
REQ-012 AXI address/data outputs SHALL remain stable while the corresponding valid is high; cmd_* changes during a transaction SHALL be ignored.

Reset
REQ-013 rst SHALL force IDLE, counter 0, all m_*valid/ready 0, sts_valid 0, sts_status OKAY, sts_rdata 0, m_awaddr/m_araddr/m_wdata 0; reset mid-transaction SHALL abandon it without sts_valid.

Structure
REQ-014 jtag_pkg SHALL hold axi_txn_sts_t (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3, TIMEOUT=4) and the FSM state enum; no sub-modules.

Verification
REQ-015 Write 0x1000/0xCAFE_F00D, aw/w ready immediately, bvalid with OKAY 2 cycles later -> sts_valid pulse, status 0, rdata 0.
REQ-016 Write with wready 3 cycles before awready -> m_wvalid drops first, single AW beat, one B, status per bresp.
REQ-017 Read 0x2000, rdata 0x1234_5678 rresp SLVERR -> sts_rdata 0x1234_5678, status 2.
REQ-018 TIMEOUT_CYCLES=8, read, arready never -> m_arvalid low after 8 cycles, status 4, cmd_ready high next cycle.
REQ-019 rst asserted in WR_RESP -> next cycle all outputs at reset values, no sts_valid.
